// File: rtl/adc_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_ctrl_if
//  Purpose  : Signal bundle between the ADC capture controller, the ADC
//             front end, the waveform RAM write port and the display.
//  Revision : 1.0 - initial release
// ============================================================================
interface adc_capture_ctrl_if #(
  parameter int ADDR_W = 10
);
  // ADC front end, trigger setup and display handshake
  logic              Sample_Valid;
  logic [7:0]        ADC_Data;
  logic [7:0]        Trigger_Gate;
  logic              Trig_Falling;
  logic              Auto_En;
  logic              Run;
  logic              Arm;
  logic              Frame_Done;
  // RAM write port and capture status
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [7:0]        Wr_Data;
  logic [ADDR_W-1:0] Read_Base;
  logic              Capture_Done;
  logic              Trig_Forced;
  logic [2:0]        State;

  // Capture controller side
  modport master (
    input  Sample_Valid, ADC_Data, Trigger_Gate, Trig_Falling, Auto_En,
           Run, Arm, Frame_Done,
    output Wr_En, Wr_Addr, Wr_Data, Read_Base, Capture_Done, Trig_Forced,
           State
  );

  // Environment side: ADC, control registers, RAM and display
  modport slave (
    output Sample_Valid, ADC_Data, Trigger_Gate, Trig_Falling, Auto_En,
           Run, Arm, Frame_Done,
    input  Wr_En, Wr_Addr, Wr_Data, Read_Base, Capture_Done, Trig_Forced,
           State
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_ctrl
//  Purpose  : Circular ADC capture into a DEPTH-deep waveform RAM with
//             pre-trigger history, level trigger (rising/falling), optional
//             auto-forced trigger and freeze-until-frame-done hold.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 256,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               Rst,
  adc_capture_ctrl_if.master bus
);

  localparam int DEPTH     = 2 ** ADDR_W;
  // Post-trigger samples still to come once the trigger sample is written
  localparam int POST_MORE = DEPTH - PRE_TRIG - 1;

  localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(POST_MORE - 1);
  localparam logic [15:0]       TO_LAST    = 16'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] read_base;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       to_cnt;
  logic [7:0]        prev;
  logic [7:0]        wr_data;
  logic              prev_valid;
  logic              finish;       // last post sample written, close capture next cycle
  logic              forced_pend;  // trigger of the capture in flight was forced
  logic              wr_en;
  logic              capture_done;
  logic              trig_forced;

  logic accept;
  logic real_trig;
  logic timeout_hit;

  // Sample acceptance and trigger qualification for the current sample
  always_comb begin
    accept      = bus.Sample_Valid &&
                  ((state == FILL) || (state == ARMED) || ((state == POST) && !finish));
    real_trig   = 1'b0;
    if (bus.Trig_Falling) begin
      real_trig = prev_valid && (prev > bus.Trigger_Gate) && (bus.ADC_Data <= bus.Trigger_Gate);
    end else begin
      real_trig = prev_valid && (prev < bus.Trigger_Gate) && (bus.ADC_Data >= bus.Trigger_Gate);
    end
    timeout_hit = bus.Auto_En && (to_cnt == TO_LAST);
  end

  // Capture sequencer, write path and registered status outputs
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state        <= IDLE;
      wp           <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      read_base    <= '0;
      wr_addr      <= '0;
      to_cnt       <= '0;
      prev         <= '0;
      wr_data      <= '0;
      prev_valid   <= 1'b0;
      finish       <= 1'b0;
      forced_pend  <= 1'b0;
      wr_en        <= 1'b0;
      capture_done <= 1'b0;
      trig_forced  <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      capture_done <= 1'b0;

      if (accept) begin
        wr_en      <= 1'b1;
        wr_addr    <= wp;
        wr_data    <= bus.ADC_Data;
        wp         <= wp + 1'b1;
        prev       <= bus.ADC_Data;
        prev_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.Run || bus.Arm) begin
            state      <= FILL;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            to_cnt     <= '0;
            prev_valid <= 1'b0;
          end
        end

        FILL: begin
          if (accept) begin
            if (pre_cnt == PRE_LAST) begin
              state   <= ARMED;
              pre_cnt <= '0;
              to_cnt  <= '0;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end

        ARMED: begin
          if (accept) begin
            if (real_trig || timeout_hit) begin
              // The trigger sample is post index 0; a real edge wins over timeout
              state       <= POST;
              trig_addr   <= wp;
              forced_pend <= !real_trig;
              to_cnt      <= '0;
              post_cnt    <= '0;
              finish      <= (POST_MORE == 0);
            end else if (to_cnt != TO_LAST) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        POST: begin
          if (finish) begin
            capture_done <= 1'b1;
            read_base    <= trig_addr - PRE_OFFSET;
            trig_forced  <= forced_pend;
            finish       <= 1'b0;
            post_cnt     <= '0;
            state        <= HOLD;
          end else if (accept) begin
            if (post_cnt == POST_LAST) begin
              finish <= 1'b1;
            end else begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (bus.Arm || (bus.Frame_Done && bus.Run)) begin
            state      <= FILL;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            to_cnt     <= '0;
            prev_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Wr_En        = wr_en;
  assign bus.Wr_Addr      = wr_addr;
  assign bus.Wr_Data      = wr_data;
  assign bus.Read_Base    = read_base;
  assign bus.Capture_Done = capture_done;
  assign bus.Trig_Forced  = trig_forced;
  assign bus.State        = state;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_ctrl
//  Purpose  : Directed self-checking bench for adc_capture_ctrl
//             (ADDR_W=4, PRE_TRIG=4, AUTO_TIMEOUT=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic Rst = 1'b0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  adc_capture_ctrl_if #(.ADDR_W(AW)) bus ();

  adc_capture_ctrl #(
    .ADDR_W      (AW),
    .PRE_TRIG    (4),
    .AUTO_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .bus(bus)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  // Count Capture_Done pulses and RAM writes away from the active edge
  always @(negedge clk) begin
    if (bus.Capture_Done === 1'b1) done_cnt++;
    if (bus.Wr_En === 1'b1) wr_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] addr;
    logic [2:0] st;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample strobe; returns 1 ns after the capturing edge
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.Sample_Valid = 1'b1;
    bus.ADC_Data     = d;
    @(posedge clk);
    #1;
    bus.Sample_Valid = 1'b0;
  endtask

  task automatic pulse(input logic arm, input logic fd);
    @(negedge clk);
    bus.Arm        = arm;
    bus.Frame_Done = fd;
    @(posedge clk);
    #1;
    bus.Arm        = 1'b0;
    bus.Frame_Done = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.Capture_Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("capture_done_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b0;
    bus.Run = 1'b0;
    bus.Auto_En = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    Rst = 1'b1;
  endtask

  initial begin
    int base_done;

    // Ramp capture: FILL 0..48, ARMED 64..112, trigger 128 at addr 8,
    // then 11 more post samples (ramp wraps 240 -> 0) ending at addr 3.
    tbl[0]  = '{8'd0,   4'd0,  3'd1};
    tbl[1]  = '{8'd16,  4'd1,  3'd1};
    tbl[2]  = '{8'd32,  4'd2,  3'd1};
    tbl[3]  = '{8'd48,  4'd3,  3'd2};
    tbl[4]  = '{8'd64,  4'd4,  3'd2};
    tbl[5]  = '{8'd80,  4'd5,  3'd2};
    tbl[6]  = '{8'd96,  4'd6,  3'd2};
    tbl[7]  = '{8'd112, 4'd7,  3'd2};
    tbl[8]  = '{8'd128, 4'd8,  3'd3};
    tbl[9]  = '{8'd144, 4'd9,  3'd3};
    tbl[10] = '{8'd160, 4'd10, 3'd3};
    tbl[11] = '{8'd176, 4'd11, 3'd3};
    tbl[12] = '{8'd192, 4'd12, 3'd3};
    tbl[13] = '{8'd208, 4'd13, 3'd3};
    tbl[14] = '{8'd224, 4'd14, 3'd3};
    tbl[15] = '{8'd240, 4'd15, 3'd3};
    tbl[16] = '{8'd0,   4'd0,  3'd3};
    tbl[17] = '{8'd16,  4'd1,  3'd3};
    tbl[18] = '{8'd32,  4'd2,  3'd3};
    tbl[19] = '{8'd48,  4'd3,  3'd3};

    bus.Sample_Valid = 1'b0;
    bus.ADC_Data     = 8'd0;
    bus.Trigger_Gate = 8'd128;
    bus.Trig_Falling = 1'b0;
    bus.Auto_En      = 1'b0;
    bus.Run          = 1'b0;
    bus.Arm          = 1'b0;
    bus.Frame_Done   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",        32'(bus.State),        32'd0);
    check("reset_wr_en",        32'(bus.Wr_En),        32'd0);
    check("reset_wr_addr",      32'(bus.Wr_Addr),      32'd0);
    check("reset_read_base",    32'(bus.Read_Base),    32'd0);
    check("reset_capture_done", 32'(bus.Capture_Done), 32'd0);
    check("reset_trig_forced",  32'(bus.Trig_Forced),  32'd0);
    @(negedge clk);
    Rst = 1'b1;

    // Rising-edge ramp capture with Run=1
    @(negedge clk);
    bus.Run = 1'b1;
    @(posedge clk);
    #1;
    check("ramp_enter_fill", 32'(bus.State), 32'd1);
    for (int i = 0; i < 20; i++) begin
      send(tbl[i].data);
      check($sformatf("ramp_wr_en[%0d]", i),   32'(bus.Wr_En),   32'd1);
      check($sformatf("ramp_wr_addr[%0d]", i), 32'(bus.Wr_Addr), 32'(tbl[i].addr));
      check($sformatf("ramp_wr_data[%0d]", i), 32'(bus.Wr_Data), 32'(tbl[i].data));
      check($sformatf("ramp_state[%0d]", i),   32'(bus.State),   32'(tbl[i].st));
    end
    @(posedge clk);
    #1;
    check("ramp_capture_done", 32'(bus.Capture_Done), 32'd1);
    check("ramp_read_base",    32'(bus.Read_Base),    32'd4);
    check("ramp_trig_forced",  32'(bus.Trig_Forced),  32'd0);
    check("ramp_state_hold",   32'(bus.State),        32'd4);
    @(posedge clk);
    #1;
    check("ramp_done_pulse_width", 32'(bus.Capture_Done), 32'd0);
    check("ramp_done_count",       32'(done_cnt),         32'd1);
    check("ramp_write_count",      32'(wr_cnt),           32'd20);

    // Frame_Done with Run=1 re-arms, then reset lands mid-POST
    pulse(1'b0, 1'b1);
    check("rearm_frame_done", 32'(bus.State), 32'd1);
    for (int i = 0; i <= 8; i++) send(8'(i * 16));
    check("midpost_state", 32'(bus.State), 32'd3);
    send(8'd144);
    send(8'd160);
    @(negedge clk);
    Rst = 1'b0;
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_state",     32'(bus.State),     32'd0);
    check("midreset_wr_en",     32'(bus.Wr_En),     32'd0);
    check("midreset_read_base", 32'(bus.Read_Base), 32'd0);
    @(negedge clk);
    Rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midreset_no_done", 32'(done_cnt),  32'd1);
    check("midreset_idle",    32'(bus.State), 32'd0);

    // Auto-forced trigger on the 8th ARMED sample (addr 11)
    @(negedge clk);
    bus.Auto_En = 1'b1;
    bus.Run     = 1'b1;
    @(posedge clk);
    #1;
    check("auto_fill", 32'(bus.State), 32'd1);
    repeat (4) send(8'd50);
    check("auto_armed", 32'(bus.State), 32'd2);
    repeat (7) send(8'd50);
    check("auto_still_armed", 32'(bus.State), 32'd2);
    send(8'd50);
    check("auto_forced_post", 32'(bus.State),   32'd3);
    check("auto_trig_addr",   32'(bus.Wr_Addr), 32'd11);
    repeat (11) send(8'd50);
    wait_done(4);
    check("auto_trig_forced", 32'(bus.Trig_Forced), 32'd1);
    check("auto_read_base",   32'(bus.Read_Base),   32'd7);
    check("auto_state_hold",  32'(bus.State),       32'd4);

    // No auto trigger: stays ARMED, write address wraps 15 -> 0
    do_reset();
    base_done = done_cnt;
    @(negedge clk);
    bus.Run = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      send(8'd50);
      check($sformatf("noauto_wr_addr[%0d]", i), 32'(bus.Wr_Addr), 32'(i % 16));
    end
    check("noauto_armed",   32'(bus.State), 32'd2);
    check("noauto_no_done", 32'(done_cnt),  32'(base_done));

    // Single shot with falling trigger at addr 5
    do_reset();
    @(negedge clk);
    bus.Trig_Falling = 1'b1;
    pulse(1'b1, 1'b0);
    check("single_fill", 32'(bus.State), 32'd1);
    repeat (5) send(8'd200);
    check("single_no_trig_above", 32'(bus.State), 32'd2);
    send(8'd100);
    check("single_fall_post", 32'(bus.State),   32'd3);
    check("single_trig_addr", 32'(bus.Wr_Addr), 32'd5);
    repeat (11) send(8'd90);
    wait_done(4);
    check("single_read_base",   32'(bus.Read_Base),   32'd1);
    check("single_trig_forced", 32'(bus.Trig_Forced), 32'd0);
    pulse(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("single_fd_ignored", 32'(bus.State), 32'd4);
    send(8'd77);
    check("single_hold_no_write", 32'(bus.Wr_En), 32'd0);
    check("single_hold_stays",    32'(bus.State), 32'd4);
    pulse(1'b1, 1'b0);
    check("single_rearm", 32'(bus.State), 32'd1);

    // Run=1 capture, then Arm and Frame_Done together in HOLD
    @(negedge clk);
    bus.Run          = 1'b1;
    bus.Trig_Falling = 1'b0;
    for (int i = 0; i <= 8; i++) send(8'(i * 16));
    check("both_trig_post", 32'(bus.State),   32'd3);
    check("both_trig_addr", 32'(bus.Wr_Addr), 32'd9);
    repeat (11) send(8'd200);
    wait_done(4);
    check("both_read_base", 32'(bus.Read_Base), 32'd5);
    send(8'd10);
    check("both_hold_no_write", 32'(bus.Wr_En), 32'd0);
    check("both_hold_state",    32'(bus.State), 32'd4);
    pulse(1'b1, 1'b1);
    check("both_to_fill", 32'(bus.State), 32'd1);
    @(posedge clk);
    #1;
    check("both_fill_stable", 32'(bus.State), 32'd1);
    repeat (3) send(8'd10);
    check("both_fill_count3", 32'(bus.State), 32'd1);
    send(8'd10);
    check("both_fill_armed", 32'(bus.State), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
